// File: rtl/div_arbiter_if.sv
// div_arbiter_if: client-side bundle for div_arbiter.
// Carries the packed per-requester valid/ready request channel and the single
// id-tagged response channel. The arbiter connects to the slave modport; client
// logic (or a bench) drives the master modport.
interface div_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DIV_W   = 32
);
  // Request side: one valid/ready pair per requester, operands packed per port
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*DIV_W-1:0] req_a;
  logic [NUM_REQ*DIV_W-1:0] req_b;

  // Response side: shared by all requesters, tagged with the requester index
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [DIV_W-1:0]         rsp_q;
  logic [DIV_W-1:0]         rsp_r;
  logic                     rsp_dz;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative divider between NUM_REQ requesters.
// Round-robin grant in IDLE, one start pulse per accepted request, then a fixed
// DIV_LATENCY wait before the divider outputs are captured (the divider has no
// busy/done of its own). The response is held until rsp_ready.
// Optional build macro DIV_ZERO_BYPASS_EN: a request with a zero divisor skips
// the divider and responds in the cycle after the accept with q = all ones,
// r = dividend, dz = 1.
module div_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DIV_W       = 32,
  parameter int DIV_LATENCY = 33
) (
  input  logic             clock,
  input  logic             reset_n,
  div_arbiter_if.slave     bus,
  output logic             div_start,
  output logic [DIV_W-1:0] div_a,
  output logic [DIV_W-1:0] div_b,
  input  logic [DIV_W-1:0] div_q,
  input  logic [DIV_W-1:0] div_r
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] a_reg, a_next;
  logic [DIV_W-1:0] b_reg, b_next;
  logic [DIV_W-1:0] q_reg, q_next;
  logic [DIV_W-1:0] r_reg, r_next;
  logic [ID_W-1:0]  id_reg, id_next;
  logic             dz_reg, dz_next;

  // Unpacked views of the packed operand buses
  logic [DIV_W-1:0] req_a_arr [NUM_REQ];
  logic [DIV_W-1:0] req_b_arr [NUM_REQ];

  // Round-robin search results
  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  int               cand;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_a_arr[gi] = bus.req_a[gi*DIV_W +: DIV_W];
    assign req_b_arr[gi] = bus.req_b[gi*DIV_W +: DIV_W];
  end

  // Find the first valid requester at or after rr_ptr, wrapping around
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant_onehot[gi] = grant_found && (grant_idx == PTR_W'(gi));
  end

  // Accept only in IDLE; reset_n gates it so ready is 0 throughout reset
  assign bus.req_ready = (reset_n && (state_reg == IDLE)) ? grant_onehot : '0;

  // Next-state and datapath update for the IDLE/START/BUSY/DONE sequence
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    q_next      = q_reg;
    r_next      = r_reg;
    id_next     = id_reg;
    dz_next     = dz_reg;

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          a_next      = req_a_arr[grant_idx];
          b_next      = req_b_arr[grant_idx];
          id_next     = ID_W'(grant_idx);
          dz_next     = (req_b_arr[grant_idx] == '0);
          rr_ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
`ifdef DIV_ZERO_BYPASS_EN
          // Zero divisor is answered locally; the divider is never started
          if (req_b_arr[grant_idx] == '0) begin
            q_next     = '1;
            r_next     = req_a_arr[grant_idx];
            state_next = DONE;
          end else begin
            state_next = START;
          end
`else
          state_next  = START;
`endif
        end
      end
      START: begin
        // div_start is high for this single cycle; the divider samples it
        // on the edge that also loads the latency counter
        cnt_next   = CNT_W'(DIV_LATENCY - 1);
        state_next = BUSY;
      end
      BUSY: begin
        if (cnt_reg == '0) begin
          q_next     = div_q;
          r_next     = div_r;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      q_reg      <= '0;
      r_reg      <= '0;
      id_reg     <= '0;
      dz_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      q_reg      <= q_next;
      r_reg      <= r_next;
      id_reg     <= id_next;
      dz_reg     <= dz_next;
    end
  end

  // Divider operands stay on the latched values until the next accept
  assign div_start = (state_reg == START);
  assign div_a     = a_reg;
  assign div_b     = b_reg;

  // Response fields come straight from registers, so they are stable in DONE
  assign bus.rsp_valid = (state_reg == DONE);
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_q     = q_reg;
  assign bus.rsp_r     = r_reg;
  assign bus.rsp_dz    = dz_reg;

endmodule
